// File: rtl/hcv_fill.sv
// -----------------------------------------------------------------------------
// hcv_fill -- rectangle-fill drawing engine, bus initiator on the hcv
// frame-buffer port.
//
// A command (x0, y0, w, h, color) is accepted on start while idle. The engine
// clips the rectangle to the screen and writes one pixel per bus transaction,
// row-major with x fastest. Each transaction holds stb/we/addr/data_out steady
// until ack. After ack the engine waits for ack to drop before it issues the
// next request, because hcv holds ack for two cycles.
//
// Ports
//   pclk, rst        clock, synchronous active-high reset
//   start            command strobe, only honoured while idle
//   abort            finish the in-flight pixel, then complete the command
//   x0, y0, w, h     rectangle: top-left corner, width, height
//   color            RGB555 fill colour
//   busy, done       command status: busy while working, done is a 1-cycle pulse
//   stb, we          bus request and write enable (always equal)
//   addr, data_out   pixel address {y, x} and {17'h0, colour}
//   ack              hcv acknowledge
// -----------------------------------------------------------------------------
module hcv_fill #(
  parameter int SCR_W = 1024,
  parameter int SCR_H = 768
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [9:0]  x0,
  input  logic [9:0]  y0,
  input  logic [10:0] w,
  input  logic [9:0]  h,
  input  logic [14:0] color,
  output logic        busy,
  output logic        done,
  output logic        stb,
  output logic        we,
  output logic [19:0] addr,
  output logic [31:0] data_out,
  input  logic        ack
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_REQ   = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [11:0] X_LIM = 12'(SCR_W);
  localparam logic [11:0] Y_LIM = 12'(SCR_H);

  logic [2:0]  r_state;
  logic [9:0]  r_x0;
  logic [9:0]  r_y0;
  logic [10:0] r_w;
  logic [9:0]  r_h;
  logic [14:0] r_color;
  logic [11:0] r_x_end;       // exclusive clipped column bound
  logic [11:0] r_y_end;       // exclusive clipped row bound
  logic [9:0]  r_cx;
  logic [9:0]  r_cy;
  logic        r_abort_pend;

  logic [11:0] w_x_sum;
  logic [11:0] w_y_sum;
  logic [11:0] w_cx_inc;
  logic [11:0] w_cy_inc;
  logic        w_empty;
  logic        w_row_end;
  logic        w_last;
  logic        w_stop;
  logic        w_active;

  // 12-bit sums cannot overflow: 1023 + 2047 < 4096.
  assign w_x_sum  = {2'b00, r_x0} + {1'b0, r_w};
  assign w_y_sum  = {2'b00, r_y0} + {2'b00, r_h};
  assign w_cx_inc = {2'b00, r_cx} + 12'd1;
  assign w_cy_inc = {2'b00, r_cy} + 12'd1;

  assign w_empty   = (r_w == '0) || (r_h == '0) ||
                     ({2'b00, r_x0} >= X_LIM) || ({2'b00, r_y0} >= Y_LIM);
  assign w_row_end = (w_cx_inc == r_x_end);
  assign w_last    = w_row_end && (w_cy_inc == r_y_end);
  // A live abort in the final GAP cycle stops the scan as well as a latched one.
  assign w_stop    = w_last || r_abort_pend || abort;
  assign w_active  = (r_state == S_SETUP) || (r_state == S_REQ) || (r_state == S_GAP);

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // here sees the pre-edge value of every other register regardless of order.
  always_ff @(posedge pclk) begin
    // NOTE: reset is synchronous; it is evaluated only on the clock edge and
    // overrides every state, including a transaction that is in flight.
    if (rst) begin
      r_state      <= S_IDLE;
      r_x0         <= '0;
      r_y0         <= '0;
      r_w          <= '0;
      r_h          <= '0;
      r_color      <= '0;
      r_x_end      <= '0;
      r_y_end      <= '0;
      r_cx         <= '0;
      r_cy         <= '0;
      r_abort_pend <= 1'b0;
    end else begin
      if (w_active && abort) begin
        r_abort_pend <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          r_abort_pend <= 1'b0;
          if (start) begin
            r_x0    <= x0;
            r_y0    <= y0;
            r_w     <= w;
            r_h     <= h;
            r_color <= color;
            r_state <= S_SETUP;
          end
        end

        S_SETUP: begin
          r_x_end <= (w_x_sum > X_LIM) ? X_LIM : w_x_sum;
          r_y_end <= (w_y_sum > Y_LIM) ? Y_LIM : w_y_sum;
          r_cx    <= r_x0;
          r_cy    <= r_y0;
          r_state <= w_empty ? S_DONE : S_REQ;
        end

        S_REQ: begin
          if (ack) begin
            r_state <= S_GAP;
          end
        end

        // Wait out the second ack cycle so it is never mistaken for the ack of
        // the next request.
        S_GAP: begin
          if (!ack) begin
            if (w_stop) begin
              r_state <= S_DONE;
            end else begin
              if (w_row_end) begin
                r_cx <= r_x0;
                r_cy <= r_cy + 10'd1;
              end else begin
                r_cx <= r_cx + 10'd1;
              end
              r_state <= S_REQ;
            end
          end
        end

        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign stb      = (r_state == S_REQ);
  assign we       = stb;
  assign busy     = w_active;
  assign done     = (r_state == S_DONE);
  assign addr     = {r_cy, r_cx};
  assign data_out = {17'h0, r_color};

endmodule

// File: tb/tb_hcv_fill.sv
// -----------------------------------------------------------------------------
// tb_hcv_fill -- self-checking bench for hcv_fill.
//
// A responder process plays hcv: it raises ack after stb has been seen for
// `lat` cycles and holds it for `ack_len` cycles. The stimulus pushes the
// expected writes of each command (computed from the clipped rectangle) into a
// queue; a monitor pops one entry per new bus request and compares it.
// -----------------------------------------------------------------------------
module tb_hcv_fill;

  logic        pclk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        ack = 1'b0;
  logic [9:0]  x0 = '0;
  logic [9:0]  y0 = '0;
  logic [10:0] w = '0;
  logic [9:0]  h = '0;
  logic [14:0] color = '0;
  logic        busy, done, stb, we;
  logic [19:0] addr;
  logic [31:0] data_out;

  hcv_fill dut (
    .pclk     (pclk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .x0       (x0),
    .y0       (y0),
    .w        (w),
    .h        (h),
    .color    (color),
    .busy     (busy),
    .done     (done),
    .stb      (stb),
    .we       (we),
    .addr     (addr),
    .data_out (data_out),
    .ack      (ack)
  );

  always #5 pclk = ~pclk;

  typedef struct packed {
    logic [19:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t    exp_q[$];
  int     n_checks = 0;
  int     n_errors = 0;
  int     lat = 4;
  int     ack_len = 2;
  int     rises = 0;
  int     dones = 0;
  longint cyc = 0;
  bit     sim_end = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // hcv model: ack after `lat` stb cycles, held for `ack_len` cycles.
  task automatic responder();
    int cnt = 0;
    int left = 0;
    while (!sim_end) begin
      @(negedge pclk);
      if (rst) begin
        ack = 1'b0; cnt = 0; left = 0;
      end else if (left > 0) begin
        left--;
        if (left == 0) ack = 1'b0;
      end else if (stb) begin
        cnt++;
        if (cnt >= lat) begin
          ack = 1'b1; left = ack_len; cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  endtask

  task automatic monitor();
    bit          prev = 1'b0;
    bit          stable = 1'b1;
    int          len = 0;
    longint      last = -1;
    logic [19:0] h_a = '0;
    logic [31:0] h_d = '0;
    wr_t         e;
    while (!sim_end) begin
      @(negedge pclk);
      cyc++;
      if (rst) begin
        prev = 1'b0; last = -1; len = 0;
        continue;
      end
      if (stb && !prev) begin
        rises++;
        check("we_eq_stb", we, 1);
        check("addr_on_screen", addr[19:10] < 10'd768, 1);
        check("write_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("wr_addr", addr, e.addr);
          check("wr_data", data_out, e.data);
        end
        if (last >= 0) check("stb_spacing", cyc - last, lat + ack_len);
        last = cyc; h_a = addr; h_d = data_out; stable = 1'b1; len = 1;
      end else if (stb) begin
        len++;
        if (addr !== h_a || data_out !== h_d || we !== 1'b1) stable = 1'b0;
      end else if (prev) begin
        check("stb_len", len, lat);
        check("req_stable", stable, 1);
      end
      if (done) begin
        dones++;
        last = -1;
        check("busy_at_done", busy, 0);
      end
      prev = stb;
    end
  endtask

  // Reference model: every on-screen pixel of the rectangle, row-major.
  task automatic push_rect(input int px, input int py, input int pw, input int ph,
                           input int pc, input int max_n, output int n);
    int  xe;
    int  ye;
    wr_t e;
    xe = (px + pw < 1024) ? px + pw : 1024;
    ye = (py + ph < 768) ? py + ph : 768;
    n = 0;
    for (int yy = py; yy < ye; yy++) begin
      for (int xx = px; xx < xe; xx++) begin
        if (n < max_n) begin
          e.addr = 20'(yy * 1024 + xx);
          e.data = 32'(pc & 32'h7FFF);
          exp_q.push_back(e);
          n++;
        end
      end
    end
  endtask

  task automatic issue(input int px, input int py, input int pw, input int ph, input int pc);
    @(negedge pclk);
    x0 = 10'(px); y0 = 10'(py); w = 11'(pw); h = 10'(ph); color = 15'(pc);
    start = 1'b1;
    @(negedge pclk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge pclk);
      n++;
    end
    if (!done) check({name, "_timeout"}, 0, 1);
  endtask

  // Run a command to completion; `ign` pulses start once while busy.
  task automatic run(input string name, input int px, input int py, input int pw,
                     input int ph, input int pc, input bit ign);
    int d0, r0, n;
    d0 = dones; r0 = rises;
    push_rect(px, py, pw, ph, pc, 1 << 30, n);
    issue(px, py, pw, ph, pc);
    check({name, "_busy_setup"}, busy, 1);
    if (ign && n > 0) begin
      repeat (3) @(negedge pclk);
      if (busy) begin
        x0 = 10'd7; y0 = 10'd9; w = 11'd5; h = 10'd5; start = 1'b1;
        @(negedge pclk);
        start = 1'b0;
      end
    end
    wait_done(name, (n + 2) * (lat + ack_len + 2) + 20);
    @(negedge pclk);
    check({name, "_done_once"}, dones - d0, 1);
    check({name, "_writes"}, rises - r0, n);
    check({name, "_queue_empty"}, exp_q.size(), 0);
    check({name, "_busy_end"}, busy, 0);
  endtask

  task automatic run_empty(input string name, input int px, input int py, input int pw, input int ph);
    int r0;
    r0 = rises;
    issue(px, py, pw, ph, 16'h1234);
    check({name, "_busy"}, busy, 1);
    check({name, "_no_early_done"}, done, 0);
    @(negedge pclk);
    check({name, "_done_2cyc"}, done, 1);
    @(negedge pclk);
    check({name, "_done_pulse"}, done, 0);
    check({name, "_no_stb"}, rises - r0, 0);
  endtask

  initial begin
    int n;
    int d0;
    int r0;
    int px, py, pw, ph;
    fork
      responder();
      monitor();
    join_none

    // Reset state.
    repeat (3) @(negedge pclk);
    check("rst_stb", stb, 0);
    check("rst_we", we, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_addr", addr, 0);
    check("rst_data", data_out, 0);
    rst = 1'b0;

    // Single pixel, hcv timing.
    run("one_px", 5, 3, 1, 1, 16'h7FFF, 1'b0);

    // Clipping at the bottom-right corner.
    run("clip", 1022, 766, 3, 2, 16'h001F, 1'b0);

    // Empty commands.
    run_empty("empty_w0", 10, 10, 0, 4);
    run_empty("empty_h0", 10, 10, 4, 0);
    run_empty("empty_x1023_w0", 1023, 5, 0, 3);
    run_empty("empty_y768", 3, 768, 5, 5);

    // Stalled responder (hcv init phase).
    lat = 1000;
    run("stall", 100, 200, 1, 1, 16'h2A55, 1'b0);
    lat = 4;

    // Abort during the 3rd pixel's request; a start while busy is ignored.
    d0 = dones; r0 = rises;
    push_rect(0, 0, 10, 1, 16'h03E0, 3, n);
    issue(0, 0, 10, 1, 16'h03E0);
    begin
      int k = 0;
      while (!(stb && addr == 20'd2) && k < 200) begin
        @(negedge pclk);
        k++;
      end
      check("abort_reach_px3", stb && addr == 20'd2, 1);
    end
    abort = 1'b1; start = 1'b1; x0 = 10'd50;
    @(negedge pclk);
    abort = 1'b0; start = 1'b0;
    wait_done("abort", 200);
    @(negedge pclk);
    check("abort_done_once", dones - d0, 1);
    check("abort_writes", rises - r0, 3);
    check("abort_queue_empty", exp_q.size(), 0);
    repeat (20) @(negedge pclk);
    check("abort_no_extra", rises - r0, 3);

    // Two-cycle ack: every pixel once.
    run("ack2", 20, 30, 4, 3, 16'h1111, 1'b1);

    // Randomised commands with varied responder timing.
    for (int i = 0; i < 10; i++) begin
      lat = $urandom_range(1, 5);
      ack_len = $urandom_range(1, 3);
      px = ($urandom_range(0, 1) == 1) ? $urandom_range(990, 1023) : $urandom_range(0, 1023);
      py = ($urandom_range(0, 1) == 1) ? $urandom_range(740, 800) : $urandom_range(0, 767);
      pw = ($urandom_range(0, 5) == 0) ? 2047 : $urandom_range(0, 40);
      ph = (pw == 2047) ? 1 : $urandom_range(0, 4);
      run($sformatf("rnd%0d", i), px, py, pw, ph, $urandom_range(0, 32767), 1'b1);
    end
    lat = 4; ack_len = 2;

    // Reset in the middle of a request.
    push_rect(40, 40, 5, 2, 16'h0ABC, 1 << 30, n);
    issue(40, 40, 5, 2, 16'h0ABC);
    begin
      int k = 0;
      while (!stb && k < 50) begin
        @(negedge pclk);
        k++;
      end
      check("rst_mid_reach_req", stb, 1);
    end
    @(negedge pclk);
    rst = 1'b1;
    @(negedge pclk);
    check("rst_mid_stb", stb, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    @(negedge pclk);
    rst = 1'b0;
    exp_q.delete();
    run("after_rst", 10, 10, 3, 2, 16'h4321, 1'b0);

    sim_end = 1'b1;
    @(negedge pclk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hcv_fill.md
Name: hcv_fill

Overview:
Rectangle-fill drawing engine. It is the bus initiator for the hcv frame-buffer port: it issues single-pixel write transactions (stb/we/addr/data, wait for ack) into the 1024x768 high-colour frame buffer. A command side (start/busy/done) receives a rectangle and a 15-bit colour. Writes proceed row-major with screen clipping, so software or a CPU-side register block can clear or fill regions without per-pixel bus traffic.

Parameters:
SCR_W, 1024, screen width in pixels (x range 0..SCR_W-1)
SCR_H, 768, screen height in pixels (y range 0..SCR_H-1)

Ports:
pclk  in  1  pixel clock; all logic on rising edge
rst  in  1  reset, synchronous, active-high
start  in  1  command strobe; sampled only in IDLE
abort  in  1  stop after the in-flight pixel completes
x0  in  10  left column
y0  in  10  top row
w  in  11  width in pixels (0..2047)
h  in  10  height in rows (0..1023)
color  in  15  RGB555 fill colour
busy  out  1  high from the cycle after start is accepted until DONE
done  out  1  one-cycle pulse at command completion
stb  out  1  bus request to hcv
we  out  1  bus write enable; equals stb
addr  out  20  pixel address {y[9:0], x[9:0]}
data_out  out  32  {17'h0, color_latched[14:0]}
ack  in  1  hcv acknowledge

Behaviour:
- Reset (rst=1 at a clock edge): state IDLE; stb=0, we=0, busy=0, done=0, addr=0, data_out=0. Reset takes precedence over everything, including mid-transaction; stb drops the next cycle.
- Latching: in IDLE with start=1, latch x0, y0, w, h and color, then go to SETUP. start while not IDLE is ignored.
- SETUP, one cycle: compute x_end = min(x0+w, SCR_W) and y_end = min(y0+h, SCR_H) in 12-bit unsigned arithmetic, both exclusive bounds.
  - Empty rectangle (w==0, h==0, x0>=SCR_W or y0>=SCR_H): go to DONE with no bus cycle.
  - Otherwise set cx=x0, cy=y0 and go to REQ.
- REQ: stb=we=1, addr={cy,cx}, data_out={17'h0,color}. Hold all of these stable until ack=1. On ack=1 go to GAP. There is no timeout: the initiator waits indefinitely, e.g. while hcv is in its init phase.
- GAP: stb=0. Stay while ack=1. hcv asserts ack for two consecutive cycles, so the second ack cycle must never be taken as the ack of a new request. When ack=0:
  - If abort_pending or the last pixel is done: go to DONE.
  - Else advance: cx+1; if cx+1==x_end then cx=x0 and cy+1. Go to REQ.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- Scan order: row-major, x fastest. Exactly (x_end-x0)*(y_end-y0) writes per command, each address written once.
- abort: sampled in every non-IDLE state into abort_pending, cleared in IDLE. An issued transaction is never withdrawn, because hcv completes it once it has seen stb. Abort in IDLE or DONE has no effect.
- Timing against hcv: the cycle after start is accepted is SETUP; stb rises the cycle after that. Each pixel takes 6 cycles: REQ for 4 cycles (ack seen in the 4th), GAP for 2 cycles. The next stb rises 6 cycles after the previous one.
- busy=1 in SETUP, REQ and GAP; busy=0 in IDLE and DONE.

Test Plan:
- 1x1 fill at (5,3), colour 0x7FFF, with an hcv-timing responder model -> exactly one write: addr=0x00C05, data_out=0x00007FFF. stb is high for 4 cycles, done pulses once, busy returns to 0.
- Clipping: x0=1022, y0=766, w=3, h=2, colour 0x001F -> 4 writes in order 0xBFBFE, 0xBFBFF, 0xBFFFE, 0xBFFFF with no address outside the screen. Check the 6-cycle stb spacing.
- Empty commands: (w=0), (h=0), (x0=1023 with w=0) and (y0=768) -> no stb ever, done pulses 2 cycles after start in each case.
- Stalled responder: ack held 0 for 1000 cycles (hcv init active) -> stb, addr and data_out stay constant throughout; the write completes normally once ack arrives.
- Abort: 10x1 fill at (0,0), abort asserted during the 3rd pixel's REQ -> exactly 3 writes (0x00000..0x00002), then done. A start issued during busy is ignored (no extra writes).
- Two-cycle ack: the responder asserts ack for 2 cycles -> no pixel is skipped or double-counted (write count equals area). Then reset asserted mid-REQ -> next cycle stb=0, busy=0, done=0; a new start afterwards runs a full clean command.
